filter_fir_mc: RTL and testbench

Parametrised multi-channel FIR engine for the audio path. It accepts one frame of CH signed samples per rts/rtr transfer and stores it in an internal circular history buffer. It then runs a sequential MAC over a runtime-selectable tap count, reading coefficients from an external coefficient RAM. Each channel result is rounded, shifted and optionally saturated, then presented on an rts/rtr output port.

---
 rtl/filter_fir_mc.sv | 214 +++++++++++++++++++++
 tb/tb_filter_fir_mc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_fir_mc.sv
// Multi-channel FIR engine: circular sample history, sequential MAC against an external
// coefficient RAM, then per-channel round/shift/saturate. Exactly one frame is in flight.
module filter_fir_mc #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int CH   = 2,
  parameter int TAPS = 512,
  parameter int PTR  = $clog2(TAPS),
  parameter int AW   = DW + CW + PTR
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [CH*DW-1:0] aud_in,
  input  logic             aud_in_rts,
  output logic             aud_in_rtr,
  output logic [CH*DW-1:0] aud_out,
  output logic             aud_out_rts,
  input  logic             aud_out_rtr,
  output logic             coeff_re,
  output logic [PTR-1:0]   coeff_rdptr,
  input  logic [CW-1:0]    coeff_data,
  input  logic [PTR:0]     rf_taps,
  input  logic [2:0]       rf_shift,
  input  logic             rf_sat,
  input  logic             ovf_clear,
  output logic             ovf_flag,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUTPUT} state_t;

  localparam logic [PTR:0] TAPS_W = (PTR+1)'(TAPS);
  localparam int           PW     = DW + CW;

  state_t               state_q;
  logic [PTR-1:0]       wr_ptr_q;
  logic [PTR:0]         fill_q;
  logic [PTR:0]         n_q;
  logic [PTR:0]         k_q;
  logic                 re_q;
  logic [PTR-1:0]       rdptr_q;
  logic [PTR-1:0]       rd_addr_q;
  logic                 tap_ok_q;
  logic                 last_q;
  logic                 mac_v_q;
  logic                 mac_ok_q;
  logic                 mac_last_q;
  logic [CH*DW-1:0]     x_q;
  logic signed [AW-1:0] acc_q [CH];
  logic [CH*DW-1:0]     out_q;
  logic                 rtr_q;
  logic                 rts_q;
  logic                 ovf_q;
  logic                 busy_q;

  logic [CH*DW-1:0]     hist_mem [TAPS];

  logic                 accept;
  logic [PTR:0]         n_d;
  logic signed [PW-1:0] prod_d [CH];
  logic [7:0]           shamt_d;
  logic signed [AW:0]   bias_d;
  logic signed [AW:0]   sum_d;
  logic signed [AW:0]   y_d;
  logic [DW-1:0]        ych_d;
  logic [CH*DW-1:0]     rnd_out_d;
  logic                 rnd_ovf_d;

  assign accept = (state_q == S_IDLE) && aud_in_rts && rtr_q;

  always_comb begin
    n_d = rf_taps;
    if (rf_taps == '0) begin
      n_d = (PTR+1)'(1);
    end else if (rf_taps > TAPS_W) begin
      n_d = TAPS_W;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < CH; c++) begin
      prod_d[c] = PW'($signed(x_q[c*DW +: DW])) * PW'($signed(coeff_data));
    end
  end

  // Sum is one bit wider than the accumulator so the rounding bias can never wrap.
  always_comb begin
    shamt_d   = 8'(CW - 1) - {5'd0, rf_shift};
    bias_d    = (AW+1)'(1) << (shamt_d - 8'd1);
    sum_d     = '0;
    y_d       = '0;
    ych_d     = '0;
    rnd_out_d = '0;
    rnd_ovf_d = 1'b0;
    for (int unsigned c = 0; c < CH; c++) begin
      sum_d = {acc_q[c][AW-1], acc_q[c]} + bias_d;
      y_d   = sum_d >>> shamt_d;
      ych_d = y_d[DW-1:0];
      if (!((&y_d[AW:DW-1]) || !(|y_d[AW:DW-1]))) begin
        rnd_ovf_d = 1'b1;
        if (rf_sat) begin
          ych_d = y_d[AW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
      end
      rnd_out_d[c*DW +: DW] = ych_d;
    end
  end

  // History contents need no reset: taps beyond the fill level are masked during MAC.
  always_ff @(posedge clk) begin
    if (accept) begin
      hist_mem[wr_ptr_q] <= aud_in;
    end
    x_q <= hist_mem[rd_addr_q];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      n_q        <= '0;
      k_q        <= '0;
      re_q       <= 1'b0;
      rdptr_q    <= '0;
      rd_addr_q  <= '0;
      tap_ok_q   <= 1'b0;
      last_q     <= 1'b0;
      mac_v_q    <= 1'b0;
      mac_ok_q   <= 1'b0;
      mac_last_q <= 1'b0;
      for (int unsigned c = 0; c < CH; c++) begin
        acc_q[c] <= '0;
      end
      out_q      <= '0;
      rtr_q      <= 1'b0;
      rts_q      <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      re_q       <= 1'b0;
      last_q     <= 1'b0;
      mac_v_q    <= re_q;
      mac_ok_q   <= tap_ok_q;
      mac_last_q <= last_q;
      ovf_q      <= (ovf_q & ~ovf_clear) | ((state_q == S_ROUND) && rnd_ovf_d);

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            n_q     <= n_d;
            fill_q  <= (fill_q == TAPS_W) ? fill_q : fill_q + 1'b1;
            k_q     <= '0;
            for (int unsigned c = 0; c < CH; c++) begin
              acc_q[c] <= '0;
            end
            rtr_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_MAC;
          end else begin
            rtr_q   <= 1'b1;
          end
        end

        // Issue stage runs one cycle ahead of accumulate; coeff_data and x_q align a cycle later.
        S_MAC: begin
          if (k_q < n_q) begin
            re_q      <= 1'b1;
            rdptr_q   <= k_q[PTR-1:0];
            rd_addr_q <= wr_ptr_q - k_q[PTR-1:0];
            tap_ok_q  <= (k_q < fill_q);
            last_q    <= (k_q == n_q - 1'b1);
            k_q       <= k_q + 1'b1;
          end
          if (mac_v_q && mac_ok_q) begin
            for (int unsigned c = 0; c < CH; c++) begin
              acc_q[c] <= acc_q[c] + AW'(prod_d[c]);
            end
          end
          if (mac_v_q && mac_last_q) begin
            state_q <= S_ROUND;
          end
        end

        S_ROUND: begin
          out_q    <= rnd_out_d;
          wr_ptr_q <= wr_ptr_q + 1'b1;
          rts_q    <= 1'b1;
          state_q  <= S_OUTPUT;
        end

        S_OUTPUT: begin
          if (aud_out_rtr) begin
            rts_q   <= 1'b0;
            rtr_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign aud_in_rtr  = rtr_q;
  assign aud_out     = out_q;
  assign aud_out_rts = rts_q;
  assign coeff_re    = re_q;
  assign coeff_rdptr = rdptr_q;
  assign ovf_flag    = ovf_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_filter_fir_mc.sv
// Scoreboard bench for filter_fir_mc: directed frames push expected outputs, a monitor pops on each transfer.
module tb_filter_fir_mc;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int CH   = 2;
  localparam int TAPS = 8;
  localparam int PTR  = $clog2(TAPS);

  logic             clk = 1'b0;
  logic             rstb;
  logic [CH*DW-1:0] aud_in = '0;
  logic             aud_in_rts = 1'b0;
  logic             aud_in_rtr;
  logic [CH*DW-1:0] aud_out;
  logic             aud_out_rts;
  logic             aud_out_rtr = 1'b1;
  logic             coeff_re;
  logic [PTR-1:0]   coeff_rdptr;
  logic [CW-1:0]    coeff_data = '0;
  logic [PTR:0]     rf_taps = '0;
  logic [2:0]       rf_shift = '0;
  logic             rf_sat = 1'b1;
  logic             ovf_clear = 1'b0;
  logic             ovf_flag;
  logic             busy;

  always #5 clk = ~clk;

  filter_fir_mc #(.DW(DW), .CW(CW), .CH(CH), .TAPS(TAPS)) u_dut (
    .clk        (clk),
    .rstb       (rstb),
    .aud_in     (aud_in),
    .aud_in_rts (aud_in_rts),
    .aud_in_rtr (aud_in_rtr),
    .aud_out    (aud_out),
    .aud_out_rts(aud_out_rts),
    .aud_out_rtr(aud_out_rtr),
    .coeff_re   (coeff_re),
    .coeff_rdptr(coeff_rdptr),
    .coeff_data (coeff_data),
    .rf_taps    (rf_taps),
    .rf_shift   (rf_shift),
    .rf_sat     (rf_sat),
    .ovf_clear  (ovf_clear),
    .ovf_flag   (ovf_flag),
    .busy       (busy)
  );

  logic [CW-1:0] coef [TAPS];
  always @(posedge clk) if (coeff_re) coeff_data <= coef[coeff_rdptr];

  typedef struct {
    logic [DW-1:0] c0;
    logic [DW-1:0] c1;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rstb === 1'b1 && aud_out_rts === 1'b1 && aud_out_rtr === 1'b1) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out", aud_out, '1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", aud_out, {mon_e.c1, mon_e.c0});
        chk("out_ovf", ovf_flag, mon_e.ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_out(input logic [DW-1:0] c0, input logic [DW-1:0] c1, input logic ovf);
    exp_t e;
    e.c0 = c0; e.c1 = c1; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int unsigned t;
    t = 0;
    while (!aud_in_rtr && t < 300) begin tick(); t++; end
    chk("in_rtr_wait", aud_in_rtr, 1);
    aud_in = {b, a};
    aud_in_rts = 1'b1;
    tick();
    aud_in_rts = 1'b0;
  endtask

  task automatic drain();
    int unsigned t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin tick(); t++; end
    chk("drain", exp_q.size(), 0);
    tick();
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    aud_in_rts = 1'b0;
    #1;
    chk("reset_outs", {aud_in_rtr, aud_out_rts, coeff_re, ovf_flag, busy, aud_out, coeff_rdptr}, '0);
    repeat (2) tick();
    rstb = 1'b1;
    tick();
    chk("rtr_after_reset", {aud_in_rtr, busy}, 2'b10);
  endtask

  task automatic clear_coef();
    for (int i = 0; i < TAPS; i++) coef[i] = '0;
  endtask

  task automatic latency(input logic [PTR:0] taps, input int unsigned want, input string nm);
    int unsigned n;
    rf_taps = taps;
    expect_out(16'h0000, 16'h0000, 1'b0);
    send(16'h1111, 16'h2222);
    n = 0;
    while (!aud_out_rts && n < 100) begin tick(); n++; end
    chk(nm, n, want);
    drain();
  endtask

  task automatic test_impulse();
    do_reset();
    clear_coef();
    coef[0] = 16'h4000; coef[1] = 16'h2000; coef[2] = 16'h1000; coef[3] = 16'h0800;
    rf_taps = 4; rf_shift = 0; rf_sat = 1;
    expect_out(16'h2000, 16'h2000, 0); send(16'h4000, 16'h4000);
    expect_out(16'h1000, 16'h1000, 0); send(16'h0000, 16'h0000);
    expect_out(16'h0800, 16'h0800, 0); send(16'h0000, 16'h0000);
    expect_out(16'h0400, 16'h0400, 0); send(16'h0000, 16'h0000);
    expect_out(16'h0000, 16'h0000, 0); send(16'h0000, 16'h0000);
    drain();
  endtask

  task automatic test_sat();
    do_reset();
    clear_coef();
    for (int i = 0; i < 4; i++) coef[i] = 16'h7FFF;
    rf_taps = 4; rf_shift = 0; rf_sat = 1;
    expect_out(16'h7FFE, 16'h7FFE, 0); send(16'h7FFF, 16'h7FFF);
    expect_out(16'h7FFF, 16'h7FFF, 1); send(16'h7FFF, 16'h7FFF);
    expect_out(16'h7FFF, 16'h7FFF, 1); send(16'h7FFF, 16'h7FFF);
    expect_out(16'h7FFF, 16'h7FFF, 1); send(16'h7FFF, 16'h7FFF);
    drain();
    rf_sat = 0;
    expect_out(16'hFFF8, 16'hFFF8, 1);
    send(16'h7FFF, 16'h7FFF);
    repeat (6) tick();
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    drain();
    chk("ovf_sticky_idle", ovf_flag, 1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("ovf_cleared", ovf_flag, 0);
  endtask

  task automatic test_latency();
    do_reset();
    clear_coef();
    rf_shift = 0; rf_sat = 1;
    latency(4'd8, 11, "lat_taps8");
    latency(4'd0, 4, "lat_taps0");
    latency(4'd15, 11, "lat_taps_clamp");
  endtask

  task automatic test_shift_bp();
    logic [CH*DW-1:0] snap;
    int unsigned bad;
    int unsigned t;
    int n0;
    do_reset();
    clear_coef();
    coef[0] = 16'h4000;
    rf_taps = 1; rf_sat = 1;
    rf_shift = 0;
    expect_out(16'h091A, 16'hF800, 0); send(16'h1234, 16'hF000);
    expect_out(16'h0001, 16'h0000, 0); send(16'h0001, 16'hFFFF);
    drain();
    rf_shift = 1;
    expect_out(16'h1234, 16'hF000, 0); send(16'h1234, 16'hF000);
    drain();
    rf_shift = 2;
    expect_out(16'h2468, 16'hE000, 0); send(16'h1234, 16'hF000);
    drain();
    rf_shift = 7;
    expect_out(16'h8000, 16'h4000, 0); send(16'hFE00, 16'h0100);
    expect_out(16'h8000, 16'h7FFF, 1); send(16'hFDFF, 16'h0200);
    drain();
    rf_shift = 0;
    aud_out_rtr = 1'b0;
    expect_out(16'h091A, 16'hF800, 1);
    send(16'h1234, 16'hF000);
    t = 0;
    while (!aud_out_rts && t < 100) begin tick(); t++; end
    chk("bp_rts_rise", aud_out_rts, 1);
    snap = aud_out;
    bad = 0;
    repeat (20) begin
      tick();
      if (aud_out !== snap || aud_out_rts !== 1'b1 || aud_in_rtr !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("bp_hold", bad, 0);
    n0 = n_out;
    aud_out_rtr = 1'b1;
    tick();
    chk("bp_release", {aud_out_rts, aud_in_rtr, busy}, 3'b010);
    repeat (3) tick();
    chk("bp_one_xfer", n_out - n0, 1);
    drain();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    do_reset();
    clear_coef();
    coef[7] = 16'h7FFF;
    rf_taps = 8; rf_shift = 0; rf_sat = 1;
    for (int i = 1; i <= 20; i++) begin
      e0 = (i > 7) ? DW'(i - 7) : '0;
      e1 = (i > 7) ? DW'(i + 93) : '0;
      expect_out(e0, e1, 0);
      send(DW'(i), DW'(i + 100));
    end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_coef();
    coef[0] = 16'h4000; coef[1] = 16'h2000; coef[2] = 16'h1000; coef[3] = 16'h0800;
    rf_taps = 4; rf_shift = 0; rf_sat = 1;
    expect_out(16'h2000, 16'h2000, 0); send(16'h4000, 16'h4000);
    expect_out(16'h3000, 16'h3000, 0); send(16'h4000, 16'h4000);
    send(16'h4000, 16'h4000);
    repeat (3) tick();
    chk("mid_busy", busy, 1);
    do_reset();
    chk("mid_no_pending", exp_q.size(), 0);
    expect_out(16'h2000, 16'h2000, 0); send(16'h4000, 16'h4000);
    drain();
  endtask

  initial begin
    rstb = 1'b0;
    clear_coef();
    test_impulse();
    test_sat();
    test_latency();
    test_shift_bp();
    test_wrap();
    test_reset_mid();
    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
